// File: rtl/snake_dir_ctrl.sv
// Snake direction command stage: filters debounced key pulses, queues legal
// turns and releases one queued turn per move tick.
module snake_dir_ctrl #(
   parameter int unsigned QDEPTH   = 2,
   parameter logic [1:0]  INIT_DIR = 2'b11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       up_press,
   input  logic       down_press,
   input  logic       left_press,
   input  logic       right_press,
   input  logic       move_tick,
   input  logic       game_run,
   input  logic       restart,
   output logic [1:0] dir,
   output logic       dir_changed,
   output logic       turn_drop,
   output logic [2:0] q_count
);

   localparam logic [2:0] QD   = 3'(QDEPTH);
   localparam logic [1:0] PMAX = 2'(QDEPTH - 1);

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == PMAX) ? 2'd0 : p + 2'd1;
   endfunction

   logic [1:0] dir_q, dir_d;
   logic [2:0] count_q, count_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] tail_q, tail_d;
   logic       changed_q, changed_d;
   logic       drop_q, drop_d;
   logic [1:0] mem_q [0:3];

   logic       push_s;
   logic       pop_s;
   logic       any_s;
   logic       multi_s;
   logic [1:0] win_s;
   logic [1:0] ref_s;

   // Next-state: press arbitration, turn legality, queue push/pop
   always_comb begin
      dir_d     = dir_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      tail_d    = tail_q;
      changed_d = 1'b0;
      drop_d    = 1'b0;
      push_s    = 1'b0;
      pop_s     = 1'b0;

      any_s   = up_press | down_press | left_press | right_press;
      multi_s = (up_press & (down_press | left_press | right_press)) |
                (down_press & (left_press | right_press)) |
                (left_press & right_press);
      if (up_press) begin
         win_s = 2'b00;
      end else if (down_press) begin
         win_s = 2'b01;
      end else if (left_press) begin
         win_s = 2'b10;
      end else begin
         win_s = 2'b11;
      end
      // Legality is judged against the last queued turn, not the current heading
      ref_s = (count_q != 3'd0) ? tail_q : dir_q;

      if (restart) begin
         dir_d    = INIT_DIR;
         count_d  = 3'd0;
         rd_ptr_d = 2'd0;
         wr_ptr_d = 2'd0;
      end else if (!game_run) begin
         count_d  = 3'd0;
         rd_ptr_d = 2'd0;
         wr_ptr_d = 2'd0;
      end else begin
         if (move_tick && (count_q != 3'd0)) begin
            pop_s     = 1'b1;
            dir_d     = mem_q[rd_ptr_q];
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            changed_d = 1'b1;
         end else begin
            pop_s = 1'b0;
         end
         if (any_s) begin
            drop_d = multi_s;
            if (win_s == ref_s) begin
               push_s = 1'b0;
            end else if (win_s == (ref_s ^ 2'b01)) begin
               drop_d = 1'b1;
            end else if ((count_q == QD) && !pop_s) begin
               drop_d = 1'b1;
            end else begin
               push_s   = 1'b1;
               wr_ptr_d = ptr_inc(wr_ptr_q);
               tail_d   = win_s;
            end
         end else begin
            drop_d = 1'b0;
         end
         count_d = count_q + {2'b00, push_s} - {2'b00, pop_s};
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dir_q     <= INIT_DIR;
         count_q   <= 3'd0;
         rd_ptr_q  <= 2'd0;
         wr_ptr_q  <= 2'd0;
         tail_q    <= INIT_DIR;
         changed_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         dir_q     <= dir_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         tail_q    <= tail_d;
         changed_q <= changed_d;
         drop_q    <= drop_d;
      end
   end

   // Turn queue storage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= 2'b00;
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= win_s;
      end
   end

   assign dir         = dir_q;
   assign dir_changed = changed_q;
   assign turn_drop   = drop_q;
   assign q_count     = count_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed self-checking bench for snake_dir_ctrl with QDEPTH=2, INIT_DIR=right.
module tb_snake_dir_ctrl;

   logic       clk;
   logic       rst;
   logic       up_press, down_press, left_press, right_press;
   logic       move_tick, game_run, restart;
   logic [1:0] dir;
   logic       dir_changed, turn_drop;
   logic [2:0] q_count;

   int n_checks = 0;
   int n_fail   = 0;

   snake_dir_ctrl #(.QDEPTH(2), .INIT_DIR(2'b11)) dut (
      .clk(clk), .rst(rst),
      .up_press(up_press), .down_press(down_press),
      .left_press(left_press), .right_press(right_press),
      .move_tick(move_tick), .game_run(game_run), .restart(restart),
      .dir(dir), .dir_changed(dir_changed), .turn_drop(turn_drop), .q_count(q_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then sample #1 after the edge that consumed them.
   task automatic step(input logic u, input logic d, input logic l, input logic r,
                       input logic t, input logic rs);
      up_press = u; down_press = d; left_press = l; right_press = r;
      move_tick = t; restart = rs;
      @(posedge clk); #1;
      up_press = 1'b0; down_press = 1'b0; left_press = 1'b0; right_press = 1'b0;
      move_tick = 1'b0; restart = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; game_run = 1'b1;
      up_press = 1'b0; down_press = 1'b0; left_press = 1'b0; right_press = 1'b0;
      move_tick = 1'b0; restart = 1'b0;
      #12;
      n_checks++; if (dir !== 2'b11) begin n_fail++; $display("FAIL rst_dir_async: got %b want 11", dir); end
      rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      n_checks++; if (dir !== 2'b11) begin n_fail++; $display("FAIL reset_dir: got %b want 11", dir); end
      n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL reset_qcount: got %0d want 0", q_count); end
      n_checks++; if (dir_changed !== 1'b0 || turn_drop !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got chg=%b drop=%b want 0 0", dir_changed, turn_drop); end
   endtask

   task automatic test_reversal();
      step(0,0,1,0,0,0);
      n_checks++; if (turn_drop !== 1'b1) begin n_fail++; $display("FAIL rev_drop: got %b want 1", turn_drop); end
      n_checks++; if (q_count !== 3'd0 || dir !== 2'b11) begin n_fail++; $display("FAIL rev_state: got q=%0d dir=%b want q=0 dir=11", q_count, dir); end
      step(0,0,0,0,0,0);
      n_checks++; if (turn_drop !== 1'b0) begin n_fail++; $display("FAIL rev_drop_len: got %b want 0", turn_drop); end
      step(0,0,0,1,0,0);
      n_checks++; if (turn_drop !== 1'b0 || q_count !== 3'd0) begin n_fail++; $display("FAIL dup_ignore: got drop=%b q=%0d want 0 0", turn_drop, q_count); end
   endtask

   task automatic test_two_turn_queue();
      step(1,0,0,0,0,0);
      n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL q2_push1: got %0d want 1", q_count); end
      step(0,0,1,0,0,0);
      n_checks++; if (q_count !== 3'd2 || turn_drop !== 1'b0) begin n_fail++; $display("FAIL q2_push2: got q=%0d drop=%b want 2 0", q_count, turn_drop); end
      step(0,0,0,0,1,0);
      n_checks++; if (dir !== 2'b00 || dir_changed !== 1'b1 || q_count !== 3'd1) begin n_fail++; $display("FAIL q2_tick1: got dir=%b chg=%b q=%0d want 00 1 1", dir, dir_changed, q_count); end
      step(0,0,0,0,0,0);
      n_checks++; if (dir_changed !== 1'b0 || dir !== 2'b00) begin n_fail++; $display("FAIL q2_chg_len: got chg=%b dir=%b want 0 00", dir_changed, dir); end
      step(0,0,0,0,1,0);
      n_checks++; if (dir !== 2'b10 || dir_changed !== 1'b1 || q_count !== 3'd0) begin n_fail++; $display("FAIL q2_tick2: got dir=%b chg=%b q=%0d want 10 1 0", dir, dir_changed, q_count); end
      step(0,0,0,0,1,0);
      n_checks++; if (dir !== 2'b10 || dir_changed !== 1'b0 || q_count !== 3'd0) begin n_fail++; $display("FAIL empty_tick: got dir=%b chg=%b q=%0d want 10 0 0", dir, dir_changed, q_count); end
      step(0,0,0,0,0,1);
      n_checks++; if (dir !== 2'b11 || dir_changed !== 1'b0) begin n_fail++; $display("FAIL restart_dir: got dir=%b chg=%b want 11 0", dir, dir_changed); end
   endtask

   task automatic test_overflow();
      step(1,0,0,0,0,0);
      step(0,0,1,0,0,0);
      step(0,1,0,0,0,0);
      n_checks++; if (q_count !== 3'd2 || turn_drop !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got q=%0d drop=%b want 2 1", q_count, turn_drop); end
      step(0,1,0,0,1,0);
      n_checks++; if (q_count !== 3'd2 || turn_drop !== 1'b0 || dir !== 2'b00 || dir_changed !== 1'b1) begin n_fail++; $display("FAIL ovf_pushpop: got q=%0d drop=%b dir=%b chg=%b want 2 0 00 1", q_count, turn_drop, dir, dir_changed); end
      step(0,0,0,0,1,0);
      n_checks++; if (dir !== 2'b10 || q_count !== 3'd1) begin n_fail++; $display("FAIL ovf_drain1: got dir=%b q=%0d want 10 1", dir, q_count); end
      step(0,0,0,0,1,0);
      n_checks++; if (dir !== 2'b01 || q_count !== 3'd0) begin n_fail++; $display("FAIL ovf_drain2: got dir=%b q=%0d want 01 0", dir, q_count); end
      step(0,0,0,0,0,1);
   endtask

   task automatic test_simultaneous_keys();
      step(1,0,1,0,0,0);
      n_checks++; if (q_count !== 3'd1 || turn_drop !== 1'b1) begin n_fail++; $display("FAIL simul_keys: got q=%0d drop=%b want 1 1", q_count, turn_drop); end
      step(0,1,0,0,0,0);
      n_checks++; if (q_count !== 3'd1 || turn_drop !== 1'b1) begin n_fail++; $display("FAIL tail_reversal: got q=%0d drop=%b want 1 1", q_count, turn_drop); end
      step(0,0,0,0,1,0);
      n_checks++; if (dir !== 2'b00) begin n_fail++; $display("FAIL simul_pop: got dir=%b want 00", dir); end
      step(0,0,0,0,0,1);
   endtask

   task automatic test_back_to_back();
      step(1,0,0,0,1,0);
      n_checks++; if (q_count !== 3'd1 || dir !== 2'b11 || dir_changed !== 1'b0) begin n_fail++; $display("FAIL empty_push_tick: got q=%0d dir=%b chg=%b want 1 11 0", q_count, dir, dir_changed); end
      step(0,0,0,0,1,0);
      n_checks++; if (dir !== 2'b00 || dir_changed !== 1'b1 || q_count !== 3'd0) begin n_fail++; $display("FAIL next_tick_pop: got dir=%b chg=%b q=%0d want 00 1 0", dir, dir_changed, q_count); end
      step(0,0,0,0,0,1);
   endtask

   task automatic test_pause_restart();
      step(1,0,0,0,0,0);
      n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL pause_prep: got %0d want 1", q_count); end
      game_run = 1'b0;
      step(0,0,0,0,0,0);
      n_checks++; if (q_count !== 3'd0 || dir !== 2'b11) begin n_fail++; $display("FAIL pause_flush: got q=%0d dir=%b want 0 11", q_count, dir); end
      step(0,0,1,0,1,0);
      n_checks++; if (dir !== 2'b11 || dir_changed !== 1'b0 || turn_drop !== 1'b0 || q_count !== 3'd0) begin n_fail++; $display("FAIL pause_ignore: got dir=%b chg=%b drop=%b q=%0d want 11 0 0 0", dir, dir_changed, turn_drop, q_count); end
      game_run = 1'b1;
      step(1,0,0,0,0,0);
      step(0,0,0,0,1,0);
      n_checks++; if (dir !== 2'b00) begin n_fail++; $display("FAIL resume_turn: got dir=%b want 00", dir); end
      step(0,0,1,0,1,1);
      n_checks++; if (dir !== 2'b11 || q_count !== 3'd0 || turn_drop !== 1'b0 || dir_changed !== 1'b0) begin n_fail++; $display("FAIL restart_prio: got dir=%b q=%0d drop=%b chg=%b want 11 0 0 0", dir, q_count, turn_drop, dir_changed); end
   endtask

   initial begin
      test_reset();
      test_reversal();
      test_two_turn_queue();
      test_overflow();
      test_simultaneous_keys();
      test_back_to_back();
      test_pause_restart();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
